mult_bus_sequencer: RTL

MULT_BUS_SEQUENCER -- requirements
Module: mult_bus_sequencer

---
 rtl/mult_bus_pkg.sv | 28 ++
 rtl/mult_bus_sequencer_if.sv | 30 +++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mult_bus_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mult_bus_pkg.sv
// Shared types and constants for the multiply bus sequencer: FSM states,
// slave register map and the default ready timeout.
package mult_bus_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SET_A,
      WR_A,
      SET_B,
      WR_B,
      SET_GO,
      GO,
      WAIT_RDY,
      DONE
   } state_e;

   localparam logic [31:0] ADDR_GO = 32'd0;
   localparam logic [31:0] ADDR_A  = 32'd1;
   localparam logic [31:0] ADDR_B  = 32'd2;

   localparam int TIMEOUT_DEF = 8;

   // Expand a client index into its one-hot done vector.
   function automatic logic [1:0] client_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mult_bus_sequencer_if.sv
// Register-style slave bus between the sequencer (master) and the multiplier
// slave; the slave decodes the address presented one cycle before valid.
interface mult_bus_sequencer_if;

   logic        valid;
   logic        start;
   logic [31:0] address;
   logic [31:0] register_data;
   logic        ready;
   logic [31:0] result_data;

   modport master (
      output valid,
      output start,
      output address,
      output register_data,
      input  ready,
      input  result_data
   );

   modport slave (
      input  valid,
      input  start,
      input  address,
      input  register_data,
      output ready,
      output result_data
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-client round-robin arbiter: the client not served last has priority;
// the pointer moves only when the caller accepts the grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       gnt_idx,
   output logic       gnt_any
);

   logic prio;

   always_comb begin
      gnt_any = |req;
      gnt_idx = req[prio] ? prio : ~prio;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (advance && gnt_any) begin
         prio <= ~gnt_idx;
      end
   end

endmodule

// File: rtl/mult_bus_sequencer.sv
// Serves two multiply clients over a register-style slave bus: writes A, B,
// kicks GO, waits for ready (bounded by TIMEOUT) and returns the product.
module mult_bus_sequencer
   import mult_bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [31:0] op_a0,
   input  logic [31:0] op_b0,
   input  logic [31:0] op_a1,
   input  logic [31:0] op_b1,
   output logic [1:0]  done,
   output logic [31:0] result,
   output logic        err,
   output logic        busy,
   mult_bus_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e           state;
   logic             cli;
   logic [31:0]      a_cap;
   logic [31:0]      b_cap;
   logic [CNT_W-1:0] wait_cnt;
   logic             gnt_idx;
   logic             gnt_any;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (state == IDLE),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Outputs are registered with the transition, so each value below is what
   // the bus shows while the FSM sits in the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         wait_cnt          <= '0;
         bus.valid         <= 1'b0;
         bus.start         <= 1'b0;
         bus.address       <= '0;
         bus.register_data <= '0;
         done              <= '0;
         result            <= '0;
         err               <= 1'b0;
         busy              <= 1'b0;
      end else begin
         bus.valid         <= 1'b0;
         bus.start         <= 1'b0;
         bus.address       <= '0;
         bus.register_data <= '0;
         done              <= '0;

         case (state)
            IDLE: begin
               if (gnt_any) begin
                  cli         <= gnt_idx;
                  a_cap       <= gnt_idx ? op_a1 : op_a0;
                  b_cap       <= gnt_idx ? op_b1 : op_b0;
                  bus.address <= ADDR_A;
                  busy        <= 1'b1;
                  state       <= SET_A;
               end
            end
            SET_A: begin
               bus.address       <= ADDR_A;
               bus.valid         <= 1'b1;
               bus.register_data <= a_cap;
               state             <= WR_A;
            end
            WR_A: begin
               bus.address <= ADDR_B;
               state       <= SET_B;
            end
            SET_B: begin
               bus.address       <= ADDR_B;
               bus.valid         <= 1'b1;
               bus.register_data <= b_cap;
               state             <= WR_B;
            end
            WR_B: begin
               bus.address <= ADDR_GO;
               state       <= SET_GO;
            end
            SET_GO: begin
               bus.address <= ADDR_GO;
               bus.valid   <= 1'b1;
               bus.start   <= 1'b1;
               state       <= GO;
            end
            GO: begin
               wait_cnt <= '0;
               state    <= WAIT_RDY;
            end
            WAIT_RDY: begin
               if (bus.ready) begin
                  result <= bus.result_data;
                  err    <= 1'b0;
                  done   <= client_onehot(cli);
                  state  <= DONE;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  result <= '0;
                  err    <= 1'b1;
                  done   <= client_onehot(cli);
                  state  <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
